// File: rtl/game_frame_timer_pkg.sv
// Shared constants, types and the wrap-or-increment rule for the game frame timer.
package game_frame_timer_pkg;

    localparam int CYCLES_PER_FRAME_60HZ = 833333;
    localparam int CYCLE_W               = 20;
    localparam int FRAME_W               = 4;

    typedef logic [CYCLE_W-1:0] cycle_t;
    typedef logic [FRAME_W-1:0] frame_t;

    // ">=" rather than "==" so a limit lowered below the current count still wraps to 0.
    function automatic frame_t next_frame_count(input frame_t count, input frame_t limit);
        return (count >= limit) ? '0 : count + frame_t'(1);
    endfunction

endpackage

// File: rtl/game_frame_timer_if.sv
// Control and status bundle between the frame timer and the game logic that consumes its ticks.
interface game_frame_timer_if;
    import game_frame_timer_pkg::*;

    logic   enable;
    frame_t skip;
    cycle_t cycle_count;
    frame_t frame_count;
    frame_t obs_frame_count;
    logic   frame_tick;
    logic   obs_tick;

    modport master (
        output enable, skip,
        input  cycle_count, frame_count, obs_frame_count, frame_tick, obs_tick
    );

    modport slave (
        input  enable, skip,
        output cycle_count, frame_count, obs_frame_count, frame_tick, obs_tick
    );
endinterface

// File: rtl/game_frame_timer_frame_skip_counter.sv
// Frame counter that advances once per frame wrap and returns to 0 after reaching its skip limit.
module frame_skip_counter
    import game_frame_timer_pkg::*;
(
    input  logic   clk,
    input  logic   resetn,
    input  logic   enable,
    input  logic   wrap_en,
    input  frame_t skip,
    output frame_t count
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (enable && wrap_en) begin
            count <= next_frame_count(count, skip);
        end
    end

endmodule

// File: rtl/game_frame_timer.sv
// Frame-rate timer: a cycle down-counter defines frames, two skip counters divide them into ticks.
module game_frame_timer
    import game_frame_timer_pkg::*;
#(
    parameter int CYCLES_PER_FRAME = CYCLES_PER_FRAME_60HZ,
    parameter int FRAME_SKIP       = 1
) (
    input  logic              clk,
    input  logic              resetn,
    game_frame_timer_if.slave bus
);

    localparam cycle_t RELOAD     = cycle_t'(CYCLES_PER_FRAME - 1);
    localparam frame_t FIXED_SKIP = frame_t'(FRAME_SKIP);

    cycle_t cycle_count;
    frame_t frame_count;
    frame_t obs_frame_count;
    logic   frame_wrap;

    assign frame_wrap = (cycle_count == '0);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cycle_count <= RELOAD;
        end else if (bus.enable) begin
            cycle_count <= frame_wrap ? RELOAD : cycle_count - cycle_t'(1);
        end
    end

    frame_skip_counter u_frame_counter (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (bus.enable),
        .wrap_en (frame_wrap),
        .skip    (FIXED_SKIP),
        .count   (frame_count)
    );

    frame_skip_counter u_obs_counter (
        .clk     (clk),
        .resetn  (resetn),
        .enable  (bus.enable),
        .wrap_en (frame_wrap),
        .skip    (bus.skip),
        .count   (obs_frame_count)
    );

    // Ticks decode the last cycle before the wrap so consumers see them one cycle ahead of the frame edge.
    always_comb begin
        bus.frame_tick = resetn && bus.enable && (frame_count == '0) && (cycle_count == cycle_t'(1));
        bus.obs_tick   = resetn && bus.enable && (obs_frame_count == '0) && (cycle_count == cycle_t'(1));
    end

    assign bus.cycle_count     = cycle_count;
    assign bus.frame_count     = frame_count;
    assign bus.obs_frame_count = obs_frame_count;

endmodule

// File: tb/tb_game_frame_timer.sv
// Self-checking bench for game_frame_timer with a 5-cycle frame and fixed skip of 1.
module tb_game_frame_timer;
    import game_frame_timer_pkg::*;

    localparam int CPF = 5;
    localparam int FS  = 1;

    typedef struct packed {
        logic [19:0] cyc;
        logic [3:0]  fc;
        logic [3:0]  oc;
        logic        ft;
        logic        ot;
    } exp_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    int m_cyc;
    int m_fc;
    int m_oc;

    exp_t sb[$];
    exp_t exp_v;
    exp_t got_v;

    game_frame_timer_if bus ();

    game_frame_timer #(
        .CYCLES_PER_FRAME (CPF),
        .FRAME_SKIP       (FS)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rn, input logic en, input int sk);
        resetn     = rn;
        bus.enable = en;
        bus.skip   = 4'(sk);
    endtask

    // Reference model: advances on the same edge as the DUT from the inputs held at that edge.
    task automatic clock_edge();
        bit wrap;
        @(posedge clk);
        if (!resetn) begin
            m_cyc = CPF - 1;
            m_fc  = 0;
            m_oc  = 0;
        end else if (bus.enable) begin
            wrap = (m_cyc == 0);
            if (wrap) begin
                m_fc = (m_fc >= FS) ? 0 : m_fc + 1;
                m_oc = (m_oc >= int'(bus.skip)) ? 0 : m_oc + 1;
            end
            m_cyc = wrap ? CPF - 1 : m_cyc - 1;
        end
        #2;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.cyc = 20'(m_cyc);
        e.fc  = 4'(m_fc);
        e.oc  = 4'(m_oc);
        e.ft  = resetn && bus.enable && (m_fc == 0) && (m_cyc == 1);
        e.ot  = resetn && bus.enable && (m_oc == 0) && (m_cyc == 1);
        return e;
    endfunction

    function automatic exp_t observe();
        return {bus.cycle_count, bus.frame_count, bus.obs_frame_count, bus.frame_tick, bus.obs_tick};
    endfunction

    task automatic do_reset(input int sk);
        drive(1'b0, 1'b1, sk);
        clock_edge();
        sb.push_back(expect_now());
        #1;
        got_v = observe();
        exp_v = sb.pop_front();
        checks++;
        if (got_v !== exp_v) begin
            failures++;
            $display("[TB] FAIL reset_state got=%h exp=%h", got_v, exp_v);
        end
        clock_edge();
    endtask

    task automatic test_reset();
        int seq[6] = '{4, 3, 2, 1, 0, 4};
        do_reset(1);
        checks++;
        if (bus.cycle_count !== 20'd4 || bus.frame_count !== 4'd0 || bus.obs_frame_count !== 4'd0) begin
            failures++;
            $display("[TB] FAIL reset_values got=%0d/%0d/%0d exp=4/0/0",
                     bus.cycle_count, bus.frame_count, bus.obs_frame_count);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 1);
            sb.push_back(expect_now());
            #1;
            got_v = observe();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL reset_model i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            if (i < 6) begin
                checks++;
                if (bus.cycle_count !== 20'(seq[i])) begin
                    failures++;
                    $display("[TB] FAIL reset_cycle_seq i=%0d got=%0d exp=%0d", i, bus.cycle_count, seq[i]);
                end
            end
            checks++;
            if (bus.frame_tick !== (i == 3 || i == 13)) begin
                failures++;
                $display("[TB] FAIL frame_tick_period i=%0d got=%b exp=%b", i, bus.frame_tick, (i == 3 || i == 13));
            end
            clock_edge();
        end
    endtask

    task automatic test_skip3();
        int oseq[5] = '{0, 1, 2, 3, 0};
        do_reset(3);
        for (int i = 0; i < 25; i++) begin
            drive(1'b1, 1'b1, 3);
            sb.push_back(expect_now());
            #1;
            got_v = observe();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL skip3_model i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            if (i % 5 == 2) begin
                checks++;
                if (bus.obs_frame_count !== 4'(oseq[i / 5])) begin
                    failures++;
                    $display("[TB] FAIL skip3_obs_seq i=%0d got=%0d exp=%0d", i, bus.obs_frame_count, oseq[i / 5]);
                end
            end
            checks++;
            if (bus.obs_tick !== (i == 3 || i == 23)) begin
                failures++;
                $display("[TB] FAIL skip3_obs_tick i=%0d got=%b exp=%b", i, bus.obs_tick, (i == 3 || i == 23));
            end
            clock_edge();
        end
    endtask

    task automatic test_skip0();
        do_reset(0);
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 1'b1, 0);
            sb.push_back(expect_now());
            #1;
            got_v = observe();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL skip0_model i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            checks++;
            if (bus.obs_tick !== (i % 5 == 3) || bus.obs_frame_count !== 4'd0) begin
                failures++;
                $display("[TB] FAIL skip0_obs i=%0d got=%b/%0d exp=%b/0", i, bus.obs_tick, bus.obs_frame_count, (i % 5 == 3));
            end
            clock_edge();
        end
    endtask

    task automatic test_skip_lower();
        bit exp_t_;
        do_reset(3);
        for (int i = 0; i < 36; i++) begin
            drive(1'b1, 1'b1, (i < 17) ? 3 : 1);
            sb.push_back(expect_now());
            #1;
            got_v = observe();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL skip_lower_model i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            exp_t_ = (i == 3 || i == 23 || i == 33);
            checks++;
            if (bus.obs_tick !== exp_t_) begin
                failures++;
                $display("[TB] FAIL skip_lower_tick i=%0d got=%b exp=%b", i, bus.obs_tick, exp_t_);
            end
            if (i == 17 || i == 20 || i == 25) begin
                checks++;
                if (bus.obs_frame_count !== ((i == 17) ? 4'd3 : (i == 20) ? 4'd0 : 4'd1)) begin
                    failures++;
                    $display("[TB] FAIL skip_lower_obs i=%0d got=%0d", i, bus.obs_frame_count);
                end
            end
            clock_edge();
        end
    endtask

    task automatic test_enable_freeze();
        bit en;
        do_reset(1);
        for (int i = 0; i < 22; i++) begin
            en = !(i >= 3 && i <= 9);
            drive(1'b1, en, 1);
            sb.push_back(expect_now());
            #1;
            got_v = observe();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL freeze_model i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            if (i >= 3 && i <= 10) begin
                checks++;
                if (bus.cycle_count !== 20'd1 || bus.frame_count !== 4'd0 || bus.frame_tick !== (i == 10)
                    || bus.obs_tick !== (i == 10)) begin
                    failures++;
                    $display("[TB] FAIL freeze_hold i=%0d got=%0d/%0d/%b/%b exp=1/0/%b/%b", i, bus.cycle_count,
                             bus.frame_count, bus.frame_tick, bus.obs_tick, (i == 10), (i == 10));
                end
            end
            if (i == 20) begin
                checks++;
                if (bus.frame_tick !== 1'b1) begin
                    failures++;
                    $display("[TB] FAIL freeze_resume_tick got=%b exp=1", bus.frame_tick);
                end
            end
            clock_edge();
        end
    endtask

    task automatic test_mid_reset();
        bit exp_ft;
        do_reset(1);
        for (int i = 0; i < 23; i++) begin
            drive((i == 7) ? 1'b0 : 1'b1, 1'b1, 1);
            sb.push_back(expect_now());
            #1;
            got_v = observe();
            exp_v = sb.pop_front();
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("[TB] FAIL mid_reset_model i=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            if (i == 7) begin
                checks++;
                if (bus.cycle_count !== 20'd2 || bus.frame_count !== 4'd1) begin
                    failures++;
                    $display("[TB] FAIL mid_reset_pre got=%0d/%0d exp=2/1", bus.cycle_count, bus.frame_count);
                end
            end
            if (i == 8) begin
                checks++;
                if (bus.cycle_count !== 20'd4 || bus.frame_count !== 4'd0 || bus.obs_frame_count !== 4'd0) begin
                    failures++;
                    $display("[TB] FAIL mid_reset_post got=%0d/%0d/%0d exp=4/0/0",
                             bus.cycle_count, bus.frame_count, bus.obs_frame_count);
                end
            end
            exp_ft = (i == 3 || i == 11 || i == 21);
            checks++;
            if (bus.frame_tick !== exp_ft) begin
                failures++;
                $display("[TB] FAIL mid_reset_tick i=%0d got=%b exp=%b", i, bus.frame_tick, exp_ft);
            end
            clock_edge();
        end
    endtask

    initial begin
        m_cyc = 0;
        m_fc  = 0;
        m_oc  = 0;
        drive(1'b0, 1'b0, 1);
        test_reset();
        test_skip3();
        test_skip0();
        test_skip_lower();
        test_enable_freeze();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/game_frame_timer.md
GAME_FRAME_TIMER -- requirements
Module: game_frame_timer

Interface
REQ-001 Parameter CYCLES_PER_FRAME, default 833333, clk cycles per 60 Hz frame at 50 MHz; legal range 3..1048575.
REQ-002 Parameter FRAME_SKIP, default 1, fixed wrap value of the frame counter; legal range 0..15.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 resetn  input  1  reset, synchronous, active-low.
REQ-005 enable  input  1  global count enable; low freezes all counters.
REQ-006 skip  input  4  dynamic wrap value of the obstacle frame counter, sampled every cycle.
REQ-007 cycle_count  output  20  cycle down-counter value.
REQ-008 frame_count  output  4  fixed-skip frame counter value.
REQ-009 obs_frame_count  output  4  dynamic-skip frame counter value.
REQ-010 frame_tick  output  1  one-cycle pulse, once per (FRAME_SKIP+1) frames.
REQ-011 obs_tick  output  1  one-cycle pulse, once per (skip+1) frames.

Function
REQ-012 cycle_count SHALL count down by 1 per enabled cycle; at 0 it SHALL reload to CYCLES_PER_FRAME-1 on the next enabled edge.
REQ-013 frame_wrap SHALL be the internal condition cycle_count==0, asserted for exactly one cycle per frame.
REQ-014 frame_count SHALL advance only on enabled edges where frame_wrap is true: if frame_count >= FRAME_SKIP it loads 0, else it increments by 1.
REQ-015 obs_frame_count SHALL follow REQ-014 using the current skip input in place of FRAME_SKIP.
REQ-016 Counter value 0 with skip or FRAME_SKIP equal to 0 SHALL stay at 0, giving a tick every frame.
REQ-017 When skip is lowered below the current obs_frame_count, the counter SHALL load 0 at the next frame_wrap; no out-of-range hold and no extra ticks.
REQ-018 frame_tick SHALL be combinational: enable && frame_count==0 && cycle_count==1.
REQ-019 obs_tick SHALL be combinational: enable && obs_frame_count==0 && cycle_count==1.
REQ-020 Each tick SHALL therefore fire one cycle before the frame_wrap of a frame whose count is 0, and SHALL be high for exactly one clk cycle.
REQ-021 With enable low, all counters SHALL hold their values and both ticks SHALL be 0.
REQ-022 All arithmetic SHALL be unsigned; no counter SHALL ever hold a value outside its legal range.

Reset
REQ-023 With resetn low at a rising edge: cycle_count loads CYCLES_PER_FRAME-1, and frame_count and obs_frame_count load 0; resetn overrides enable.
REQ-024 Reset asserted mid-frame SHALL restart the full frame period; the first frame_tick SHALL occur CYCLES_PER_FRAME-2 cycles after the first edge with resetn high.
REQ-025 Ticks SHALL be 0 in any cycle in which resetn is low.

Structure
REQ-026 A shared package SHALL hold CYCLES_PER_FRAME_60HZ (833333), the 20-bit cycle width and the 4-bit frame width constants.
REQ-027 One sub-module, frame_skip_counter, SHALL be used.
- Ports: clk, resetn, enable, wrap_en, skip[3:0], count[3:0].
- Instantiated twice: once with skip tied to FRAME_SKIP, once with skip tied to the skip input.
REQ-028 The cycle down-counter and the tick decode SHALL live in game_frame_timer.

Verification
REQ-029 Bench SHALL use CYCLES_PER_FRAME=5, FRAME_SKIP=1 and cover the following scenarios:
- Reset release: cycle_count sequence 4,3,2,1,0,4.
  - frame_tick high only in the cycle with cycle_count==1 of frame 0.
  - frame_tick period is 10 cycles.
- skip=3 held: obs_frame_count sequence 0,1,2,3,0; obs_tick period is 20 cycles.
- skip=0: obs_tick every 5 cycles; obs_frame_count constant 0.
- obs_frame_count=3, then skip changed to 1: next frame_wrap loads 0; no tick lost or duplicated beyond the new period.
- enable low for 7 cycles mid-frame: all counts frozen, ticks 0; counting resumes exactly where it stopped.
- resetn low for 1 cycle while cycle_count==2 and frame_count==1: next values 4, 0, 0; frame_tick 3 cycles after release.
